d_input_debouncer: RTL and testbench
====================================

// Module: d_input_debouncer
// PURPOSE
//  Upstream conditioning stage for the D flip-flop blocks: takes a raw, asynchronous,
//  possibly bouncing level d_raw, synchronises it into clk, rejects pulses shorter than
//  DEBOUNCE_CYCLES, and drives a clean registered level q/qb usable as a flop d input.
//  Optional one-cycle rise/fall pulses for downstream counters/FSMs.
// PARAMETERS
//  SYNC_STAGES      2  synchroniser flop count (legal >= 2)
//  DEBOUNCE_CYCLES  4  consecutive equal synchronised samples required to accept a change (legal >= 1)
//  CNT_W            localparam = $clog2(DEBOUNCE_CYCLES+1); debounce counter width
// PORTS
//  clk         in   1  rising-edge clock
//  sync_reset  in   1  synchronous reset, active-high
//  d_raw       in   1  raw asynchronous input level
//  q           out  1  debounced level
//  qb          out  1  complement of q, always ~q
//  busy        out  1  1 while a candidate change is being counted (PEND_* state)
//  rise        out  1  one-cycle pulse, q went 0->1 (see CONFIGURATION)
//  fall        out  1  one-cycle pulse, q went 1->0 (see CONFIGURATION)
// BEHAVIOUR
//  - One clock clk; reset sync_reset is synchronous, active-high, sampled on posedge clk.
//  - Reset values: sync chain all 0, state STABLE_LO, cnt 0, q=0, qb=1, rise=0, fall=0, busy=0.
//  - Reset mid-count discards the pending change; reset wins over every other event.
//  - Sync chain: s = last stage of SYNC_STAGES flops shifting d_raw; only s feeds the FSM.
//  - FSM states: STABLE_LO, PEND_HI, STABLE_HI, PEND_LO. All outputs registered.
//  - STABLE_LO: s=0 -> stay. s=1 -> if DEBOUNCE_CYCLES==1: q<=1, STABLE_HI;
//    else cnt<=1, PEND_HI.
//  - PEND_HI: s=0 -> cnt<=0, STABLE_LO (glitch rejected, q unchanged, no pulse).
//    s=1 -> if cnt+1==DEBOUNCE_CYCLES: q<=1, cnt<=0, STABLE_HI; else cnt<=cnt+1.
//  - STABLE_HI / PEND_LO: mirror of above with polarity inverted; q<=0 on acceptance.
//  - busy = (state==PEND_HI)||(state==PEND_LO), registered with state.
//  - Latency: d_raw steady change first captured at edge 0 -> q changes at edge
//    SYNC_STAGES+DEBOUNCE_CYCLES-1 (defaults: edge 5).
//  - Any s reversal during PEND_* restarts from the stable state; a later reversal
//    back needs a full DEBOUNCE_CYCLES again (no partial credit).
//  - cnt never exceeds DEBOUNCE_CYCLES-1 when held; no wrap-around possible.
//  - qb is always the exact complement of q, same cycle, including reset.
// CONFIGURATION
//  - Macro DEBOUNCE_EDGE_PULSE_EN:
//    defined   -> rise=1 for exactly the one cycle after the edge that sets q 0->1;
//                 fall likewise for 1->0; never both high; both 0 during/after reset.
//    undefined -> rise and fall ports remain, tied to constant 0; no pulse flops built.
// TESTING
//  1. Reset: assert sync_reset 3 cycles with d_raw=1 -> q=0, qb=1, busy=0, rise=fall=0
//     throughout; release -> q rises at edge 5 after first capture (defaults).
//  2. Clean rise/fall: d_raw 0->1 held 20 cycles then 1->0 -> q=1 at edge 5, rise single
//     1-cycle pulse; q=0 five edges after falling capture, fall single pulse (EN defined).
//  3. Glitch reject: d_raw high for 3 cycles then low (DEBOUNCE_CYCLES=4) -> busy pulses,
//     q stays 0, no rise pulse; d_raw high exactly 4 synced cycles -> q=1.
//  4. Bounce: d_raw toggling every 2 cycles for 16 cycles then held 1 -> q unchanged
//     during bounce, q=1 exactly SYNC_STAGES+DEBOUNCE_CYCLES-1 edges after last toggle capture.
//  5. Reset mid-count: sync_reset asserted while busy=1 in PEND_HI -> next cycle q=0,
//     busy=0, cnt=0; no rise pulse emitted.
//  6. Build variants: DEBOUNCE_CYCLES=1 -> q follows s with no extra delay (edge 2);
//     DEBOUNCE_EDGE_PULSE_EN undefined -> rise=fall=0 across tests 2-4.

Source files
------------

// File: rtl/d_input_debouncer.sv
// Synchroniser plus debounce FSM producing a clean registered level q/qb.
// Optional rise/fall pulses built when DEBOUNCE_EDGE_PULSE_EN is defined.
module d_input_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic sync_reset,
    input  logic d_raw,
    output logic q,
    output logic qb,
    output logic busy,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   s;

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             q_q;
    logic             q_d;
    logic             qb_q;
    logic             qb_d;
    logic             busy_q;
    logic             busy_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_raw};
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        unique case (state_q)
            STABLE_LO: begin
                if (s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        q_d     = 1'b1;
                        state_d = STABLE_HI;
                    end else begin
                        cnt_d   = CNT_ONE;
                        state_d = PEND_HI;
                    end
                end
            end
            PEND_HI: begin
                if (!s) begin
                    cnt_d   = '0;
                    state_d = STABLE_LO;
                end else if (cnt_q == CNT_LAST) begin
                    q_d     = 1'b1;
                    cnt_d   = '0;
                    state_d = STABLE_HI;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        q_d     = 1'b0;
                        state_d = STABLE_LO;
                    end else begin
                        cnt_d   = CNT_ONE;
                        state_d = PEND_LO;
                    end
                end
            end
            PEND_LO: begin
                if (s) begin
                    cnt_d   = '0;
                    state_d = STABLE_HI;
                end else if (cnt_q == CNT_LAST) begin
                    q_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = STABLE_LO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                cnt_d   = '0;
                q_d     = 1'b0;
                state_d = STABLE_LO;
            end
        endcase
    end

    // busy and qb are flopped alongside state/q so every output is registered
    always_comb begin
        busy_d = (state_d == PEND_HI) || (state_d == PEND_LO);
        qb_d   = ~q_d;
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            sync_q  <= '0;
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            q_q     <= 1'b0;
            qb_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            qb_q    <= qb_d;
            busy_q  <= busy_d;
        end
    end

    assign q    = q_q;
    assign qb   = qb_q;
    assign busy = busy_q;

`ifdef DEBOUNCE_EDGE_PULSE_EN
    logic rise_q;
    logic rise_d;
    logic fall_q;
    logic fall_d;

    always_comb begin
        rise_d = q_d & ~q_q;
        fall_d = ~q_d & q_q;
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_d_input_debouncer.sv
// Directed bench for d_input_debouncer: default build plus a DEBOUNCE_CYCLES=1 copy.
module tb_d_input_debouncer;

`ifdef DEBOUNCE_EDGE_PULSE_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic clk = 1'b0;
    logic sync_reset;
    logic d_raw;
    logic q, qb, busy, rise, fall;
    logic q1, qb1, busy1, rise1, fall1;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    d_input_debouncer dut_a (
        .clk(clk), .sync_reset(sync_reset), .d_raw(d_raw),
        .q(q), .qb(qb), .busy(busy), .rise(rise), .fall(fall)
    );

    d_input_debouncer #(.DEBOUNCE_CYCLES(1)) dut_b (
        .clk(clk), .sync_reset(sync_reset), .d_raw(d_raw),
        .q(q1), .qb(qb1), .busy(busy1), .rise(rise1), .fall(fall1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic expa(input string tag, input bit eq, input bit eb,
                        input bit er, input bit ef);
        check({tag, ".q"}, q, eq);
        check({tag, ".qb"}, qb, ~eq);
        check({tag, ".busy"}, busy, eb);
        check({tag, ".rise"}, rise, er & PEN);
        check({tag, ".fall"}, fall, ef & PEN);
    endtask

    task automatic expb(input string tag, input bit eq, input bit eb);
        check({tag, ".q1"}, q1, eq);
        check({tag, ".qb1"}, qb1, ~eq);
        check({tag, ".busy1"}, busy1, eb);
    endtask

    task automatic expq(input string tag, input bit eq);
        check({tag, ".q"}, q, eq);
        check({tag, ".qb"}, qb, ~eq);
        check({tag, ".rise"}, rise, 1'b0);
        check({tag, ".fall"}, fall, 1'b0);
    endtask

    initial begin
        // reset held 3 cycles with d_raw high
        sync_reset = 1'b1;
        d_raw      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expa($sformatf("rst%0d", i), 0, 0, 0, 0);
            expb($sformatf("rst%0d", i), 0, 0);
        end
        sync_reset = 1'b0;

        // rising acceptance: edge 5 (default), edge 2 (DEBOUNCE_CYCLES=1)
        tick(); expa("r_e0", 0, 0, 0, 0); expb("r_e0", 0, 0);
        tick(); expa("r_e1", 0, 0, 0, 0); expb("r_e1", 0, 0);
        tick(); expa("r_e2", 0, 1, 0, 0); expb("r_e2", 1, 0);
        tick(); expa("r_e3", 0, 1, 0, 0);
        tick(); expa("r_e4", 0, 1, 0, 0);
        tick(); expa("r_e5", 1, 0, 1, 0);
        tick(); expa("r_e6", 1, 0, 0, 0);
        for (int i = 7; i < 20; i++) begin
            tick();
            expa($sformatf("r_hold%0d", i), 1, 0, 0, 0);
        end

        // clean fall
        d_raw = 1'b0;
        tick(); expa("f_e0", 1, 0, 0, 0); expb("f_e0", 1, 0);
        tick(); expa("f_e1", 1, 0, 0, 0); expb("f_e1", 1, 0);
        tick(); expa("f_e2", 1, 1, 0, 0); expb("f_e2", 0, 0);
        tick(); expa("f_e3", 1, 1, 0, 0);
        tick(); expa("f_e4", 1, 1, 0, 0);
        tick(); expa("f_e5", 0, 0, 0, 1);
        tick(); expa("f_e6", 0, 0, 0, 0);
        tick(); tick();

        // 3-cycle glitch rejected
        d_raw = 1'b1;
        tick(); expa("g_e0", 0, 0, 0, 0);
        tick(); expa("g_e1", 0, 0, 0, 0);
        tick(); expa("g_e2", 0, 1, 0, 0);
        d_raw = 1'b0;
        tick(); expa("g_e3", 0, 1, 0, 0);
        tick(); expa("g_e4", 0, 1, 0, 0);
        tick(); expa("g_e5", 0, 0, 0, 0);
        tick(); expa("g_e6", 0, 0, 0, 0);
        tick(); expa("g_e7", 0, 0, 0, 0);

        // exactly 4 synced cycles high is accepted, then falls back
        d_raw = 1'b1;
        tick(); expa("x_e0", 0, 0, 0, 0);
        tick(); expa("x_e1", 0, 0, 0, 0);
        tick(); expa("x_e2", 0, 1, 0, 0);
        tick(); expa("x_e3", 0, 1, 0, 0);
        d_raw = 1'b0;
        tick(); expa("x_e4", 0, 1, 0, 0);
        tick(); expa("x_e5", 1, 0, 1, 0);
        tick(); expa("x_e6", 1, 1, 0, 0);
        tick(); expa("x_e7", 1, 1, 0, 0);
        tick(); expa("x_e8", 1, 1, 0, 0);
        tick(); expa("x_e9", 0, 0, 0, 1);
        tick(); expa("x_e10", 0, 0, 0, 0);

        // bounce every 2 cycles for 16 cycles, then held high
        for (int i = 0; i < 16; i++) begin
            d_raw = ((i / 2) % 2 == 0) ? 1'b1 : 1'b0;
            tick();
            expq($sformatf("b_%0d", i), 0);
        end
        d_raw = 1'b1;
        tick(); expa("bh_e0", 0, 0, 0, 0);
        tick(); expa("bh_e1", 0, 0, 0, 0);
        tick(); expa("bh_e2", 0, 1, 0, 0);
        tick(); expa("bh_e3", 0, 1, 0, 0);
        tick(); expa("bh_e4", 0, 1, 0, 0);
        tick(); expa("bh_e5", 1, 0, 1, 0);
        tick(); expa("bh_e6", 1, 0, 0, 0);

        // return low, then reset in the middle of PEND_HI
        d_raw = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        expa("m_low", 0, 0, 0, 0);
        d_raw = 1'b1;
        tick(); tick(); tick();
        tick(); expa("m_e3", 0, 1, 0, 0);
        sync_reset = 1'b1;
        tick(); expa("m_rst", 0, 0, 0, 0);
        check("m_rst.cnt", dut_a.cnt_q == '0, 1'b1);
        sync_reset = 1'b0;
        tick(); expa("m_e0", 0, 0, 0, 0);
        tick(); expa("m_e1", 0, 0, 0, 0);
        tick(); expa("m_e2", 0, 1, 0, 0);
        tick(); expa("m_e3b", 0, 1, 0, 0);
        tick(); expa("m_e4", 0, 1, 0, 0);
        tick(); expa("m_e5", 1, 0, 1, 0);
        tick(); expa("m_e6", 1, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
